// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-side bundle for the hazard/forwarding controller: hazard-relevant
// fields of the ID, EX and MEM stages, plus the hold/flush, forwarding-select
// and performance-counter outputs returned to the pipeline.
interface hazard_fwd_ctrl_if #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_wb_en;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_wb_en;
  logic                  branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_en;
  logic                  idex_flush;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [1:0]            ctrl_state;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  // Pipeline datapath side: presents stage information, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_rd, ex_wb_en, ex_mem_read, mem_rd, mem_wb_en,
    output branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    input  fwd_a_sel, fwd_b_sel, ctrl_state, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_rd, ex_wb_en, ex_mem_read, mem_rd, mem_wb_en,
    input  branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    output fwd_a_sel, fwd_b_sel, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline.
// Picks one action per cycle (freeze for memory, flush for taken branch,
// bubble for load-use, or run), drives the hold/flush controls from it,
// pre-decodes the EX operand forwarding selects in ID and registers them
// into EX, and keeps saturating stall/flush cycle counters.
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10,
    MEM_WAIT = 2'b11
  } ctrl_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_t      state_q;
  ctrl_state_t      action;
  logic             mem_wait;
  logic             load_use;
  logic             pc_en_c;
  logic             ifid_en_c;
  logic             ifid_flush_c;
  logic             idex_en_c;
  logic             idex_flush_c;
  logic [1:0]       fwd_a_dec;
  logic [1:0]       fwd_b_dec;
  logic [1:0]       fwd_a_q;
  logic [1:0]       fwd_b_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // EX producer is younger than MEM producer, so its result must win.
  function automatic logic [1:0] fwd_decode(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  used,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  ex_wb_en,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  mem_wb_en
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && ex_wb_en && (src == ex_rd)) begin
      sel = 2'b01;
    end else if (used && mem_wb_en && (src == mem_rd)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Hazard events and forwarding pre-decode for the instruction now in ID.
  always_comb begin
    mem_wait  = bus.mem_req & ~bus.mem_ready;
    load_use  = bus.ex_mem_read & bus.ex_wb_en &
                ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                 (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));
    fwd_a_dec = fwd_decode(bus.id_rs1, bus.id_rs1_used, bus.ex_rd,
                           bus.ex_wb_en, bus.mem_rd, bus.mem_wb_en);
    fwd_b_dec = fwd_decode(bus.id_rs2, bus.id_rs2_used, bus.ex_rd,
                           bus.ex_wb_en, bus.mem_rd, bus.mem_wb_en);
  end

  // Next state: the action taken this cycle, in priority order.
  always_comb begin
    action = RUN;
    if (rst) begin
      action = RUN;
    end else if (mem_wait) begin
      action = MEM_WAIT;
    end else if (bus.branch_taken) begin
      action = FLUSH;
    end else if (load_use) begin
      action = LU_STALL;
    end
  end

  // Hold and flush controls implied by the chosen action.
  always_comb begin
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_en_c    = 1'b1;
    idex_flush_c = 1'b0;
    case (action)
      MEM_WAIT: begin
        pc_en_c   = 1'b0;
        ifid_en_c = 1'b0;
        idex_en_c = 1'b0;
      end
      FLUSH: begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end
      LU_STALL: begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State register records the action of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= action;
    end
  end

  // Forwarding selects move into EX with the ID/EX register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (idex_en_c) begin
      fwd_a_q <= idex_flush_c ? 2'b00 : fwd_a_dec;
      fwd_b_q <= idex_flush_c ? 2'b00 : fwd_b_dec;
    end
  end

  // Saturating counters for stalled and flushed cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (((action == MEM_WAIT) || (action == LU_STALL)) && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 1'b1;
      end
      if ((action == FLUSH) && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign bus.pc_en      = pc_en_c;
  assign bus.ifid_en    = ifid_en_c;
  assign bus.ifid_flush = ifid_flush_c;
  assign bus.idex_en    = idex_en_c;
  assign bus.idex_flush = idex_flush_c;
  assign bus.fwd_a_sel  = fwd_a_q;
  assign bus.fwd_b_sel  = fwd_b_q;
  assign bus.ctrl_state = state_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the five-stage processor. It computes the 2-bit select codes for the EX-stage ALU operand forwarding muxes (the 4-input generic mux) one stage early and registers them into EX. It also generates PC / IF-ID / ID-EX hold and flush controls for load-use hazards, taken branches and multi-cycle memory accesses. It tracks controller state and counts stall and flush cycles for performance visibility.

## Interface
Parameters:
- REG_ADDR_W, 3, register-file address width.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the instruction in ID actually reads that source.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_wb_en  in  1  instruction in EX writes the register file.
- ex_mem_read  in  1  instruction in EX is a load.
- mem_rd  in  REG_ADDR_W  destination register of the instruction in MEM.
- mem_wb_en  in  1  instruction in MEM writes the register file.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  instruction in MEM is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC may update.
- ifid_en  out  1  IF/ID register may load.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX register may load.
- idex_flush  out  1  ID/EX loads a bubble.
- fwd_a_sel, fwd_b_sel  out  2  EX operand mux selects: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 is never driven.
- ctrl_state  out  2  00 RUN, 01 LU_STALL, 10 FLUSH, 11 MEM_WAIT; this is the action taken in the previous cycle.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Event detection is combinational, evaluated every cycle:
  - mem_wait = mem_req & ~mem_ready.
  - load_use = ex_mem_read & ex_wb_en & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Priority is rst > mem_wait > branch_taken > load_use.
- Control outputs (combinational):
  - mem_wait: pc_en = ifid_en = idex_en = 0; no flushes.
  - else branch_taken: pc_en = ifid_en = idex_en = 1; ifid_flush = idex_flush = 1.
  - else load_use: pc_en = ifid_en = 0; idex_en = 1; idex_flush = 1.
  - else: all enables 1, all flushes 0.
- Forwarding pre-decode in ID, per source s (s = rs1/rs2):
  - If s is used, ex_wb_en is set and s==ex_rd: 01 (the producer is in EX/MEM when the consumer reaches EX).
  - Else if s is used, mem_wb_en is set and s==mem_rd: 10.
  - Else: 00. The EX match wins over the MEM match.
- Select register update (registered fwd_*_sel):
  - When idex_en=0: hold.
  - Else when idex_flush=1: load 00.
  - Else: load the pre-decoded value.
- ctrl_state register next value: MEM_WAIT, FLUSH, LU_STALL or RUN, matching the action chosen this cycle.
- stall_cnt increments on every cycle with mem_wait or (load_use & ~branch_taken).
- flush_cnt increments on every cycle with branch_taken & ~mem_wait.
- Both counters saturate at all-ones.

## Timing
- Reset values: ctrl_state=RUN, fwd_a_sel=fwd_b_sel=00, stall_cnt=flush_cnt=0.
- During a cycle with rst=1, the combinational outputs show RUN behaviour: enables 1, flushes 0.
- Forwarding select latency is one cycle: decoded in ID at cycle n, visible at EX in cycle n+1.
- Load-use inserts exactly one bubble. In the following cycle the load is in MEM and EX holds the bubble (ex_wb_en=0), so the pre-decode yields 10.
- mem_wait may last any number of cycles. The pipeline freezes, with selects and the ID instruction held, until the cycle mem_ready=1.
- Simultaneous branch_taken and load_use: the flush wins and no stall is counted, because the ID instruction is discarded.
- mem_wait together with branch_taken: the freeze wins. The branch is re-presented after release and is flushed then.
- rst asserted mid-stall or mid-wait: the next cycle is RUN with cleared selects and counters.
- A register-address-0 destination is not special-cased; the decode stage must deassert wb_en.

## Test plan
- Back-to-back ALU dependency: EX writes r3 and ID reads r3 as rs1 → next cycle fwd_a_sel=01, no stall, ctrl_state=RUN.
- Two-apart dependency: MEM writes r5 and ID reads r5 as rs2, no EX match → next cycle fwd_b_sel=10. EX and MEM both writing r5 → 01.
- Load-use: EX load to r2 and ID reads r2 → pc_en=ifid_en=0 and idex_flush=1 for exactly 1 cycle; stall_cnt=1; the following cycle's decode gives 10.
- Branch with load-use in the same cycle → ifid_flush=idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt=0, ctrl_state=FLUSH next cycle.
- mem_req held 4 cycles, with mem_ready in the 4th → enables 0 for 3 cycles, selects held, stall_cnt=3, ctrl_state=MEM_WAIT; RUN resumes after.
- Reset during MEM_WAIT, and counter saturation with CNT_W=4 after 20 stalls → reset clears state, selects and counters; the counter saturates and holds at 15.
